// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with row synchronizer,
// debounced press/release detection and a one-cycle valid strobe.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] DMAX = SW'(DEBOUNCE_CNT);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  state_t        state_q, state_d;
  logic [3:0]    sync_q, row_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d, row_q, row_d;
  logic [SW-1:0] stab_q, stab_d, rel_q, rel_d, stab_inc, rel_inc;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          sample, row_bit;
  logic [1:0]    win;
  always_comb begin
    sample   = cnt_q == CW'(SCAN_DIV - 1);
    win      = !row_s_q[0] ? 2'd0 : !row_s_q[1] ? 2'd1 : !row_s_q[2] ? 2'd2 : 2'd3;
    row_bit  = row_s_q[row_q];
    stab_inc = (stab_q == DMAX) ? stab_q : stab_q + 1'b1;
    rel_inc  = (rel_q == DMAX) ? rel_q : rel_q + 1'b1;
    state_d  = state_q;
    cnt_d    = sample ? '0 : cnt_q + 1'b1;
    col_d    = col_q;
    row_d    = row_q;
    stab_d   = stab_q;
    rel_d    = rel_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (row_s_q != 4'hf) begin
            row_d  = win;
            stab_d = SW'(1);
            // A single-sample debounce accepts on the detect sample itself
            if (DEBOUNCE_CNT == 1) begin
              state_d = HELD;
              code_d  = {win, col_q};
              valid_d = 1'b1;
              stab_d  = '0;
              rel_d   = '0;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!row_bit) begin
            stab_d = stab_inc;
            if (stab_inc == DMAX) begin
              state_d = HELD;
              code_d  = {row_q, col_q};
              valid_d = 1'b1;
              stab_d  = '0;
              rel_d   = '0;
            end
          end else begin
            state_d = SCAN;
            stab_d  = '0;
          end
        end
        HELD: begin
          if (row_bit) begin
            rel_d = rel_inc;
            if (rel_inc == DMAX) begin
              state_d = SCAN;
              col_d   = col_q + 2'd1;
              rel_d   = '0;
            end
          end else begin
            rel_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      sync_q  <= 4'hf;
      row_s_q <= 4'hf;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      stab_q  <= '0;
      rel_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= row_in;
      row_s_q <= sync_q;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      stab_q  <= stab_d;
      rel_q   <= rel_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end
  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = state_q == HELD;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: physical keypad matrix drives the rows; a per-sample
// reference model predicts every output cycle by cycle.
module tb_keypad_scanner;
  localparam int D = 3;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row_in, col_out, key_code;
  logic        key_valid, key_held;
  logic [15:0] pressed;
  int vectors = 0;
  int miscompares = 0;
  int mc, mmode, mrow, mcnt, mrc;
  logic [3:0] mcode;
  logic mvalid;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(D)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to the driven (low) column
  always_comb
    for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);

  task automatic model_reset();
    mc = 0; mmode = 0; mrow = 0; mcnt = 0; mrc = 0; mcode = 4'h0; mvalid = 1'b0;
  endtask

  task automatic accept();
    mcode = 4'(mrow * 4 + mc); mvalid = 1'b1; mmode = 2; mrc = 0;
  endtask

  task automatic model_step();
    int found;
    mvalid = 1'b0;
    if (mmode == 0) begin
      found = -1;
      for (int r = 3; r >= 0; r--) if (pressed[r*4 + mc]) found = r;
      if (found >= 0) begin
        mrow = found; mcnt = 1;
        if (mcnt >= D) accept(); else mmode = 1;
      end else mc = (mc + 1) % 4;
    end else if (mmode == 1) begin
      if (pressed[mrow*4 + mc]) begin
        mcnt++;
        if (mcnt >= D) accept();
      end else begin
        mmode = 0; mcnt = 0;
      end
    end else begin
      if (!pressed[mrow*4 + mc]) begin
        mrc++;
        if (mrc >= D) begin mmode = 0; mc = (mc + 1) % 4; mrc = 0; end
      end else mrc = 0;
    end
  endtask

  task automatic check(input int c);
    logic [3:0] ec;
    ec = 4'hf; ec[mc] = 1'b0;
    vectors += 4;
    assert (col_out === ec) else begin miscompares++; $error("FAIL col_out got %b exp %b", col_out, ec); end
    assert (key_code === mcode) else begin miscompares++; $error("FAIL key_code got %b exp %b", key_code, mcode); end
    assert (key_valid === (c == 0 && mvalid)) else begin miscompares++; $error("FAIL key_valid got %b exp %b", key_valid, (c == 0 && mvalid)); end
    assert (key_held === (mmode == 2)) else begin miscompares++; $error("FAIL key_held got %b exp %b", key_held, (mmode == 2)); end
  endtask

  // One dwell window: caller is at the negedge just after a sample edge
  task automatic window(input logic [15:0] keys);
    pressed = keys;
    for (int c = 0; c < 4; c++) begin
      check(c);
      @(negedge clk);
    end
    model_step();
  endtask

  task automatic press_until_held(input logic [15:0] keys);
    for (int i = 0; i < 24 && mmode != 2; i++) window(keys);
    vectors++;
    assert (key_held === 1'b1) else begin miscompares++; $error("FAIL held_reached got %b exp 1", key_held); end
  endtask

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] k;
    k = '0; k[r*4 + c] = 1'b1;
    return k;
  endfunction

  initial begin
    logic [15:0] k;
    int sel, len;
    rst_n = 1'b0; pressed = '0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors += 3;
    assert (col_out === 4'b1110) else begin miscompares++; $error("FAIL rst_col got %b exp 1110", col_out); end
    assert (key_held === 1'b0) else begin miscompares++; $error("FAIL rst_held got %b exp 0", key_held); end
    assert (key_valid === 1'b0) else begin miscompares++; $error("FAIL rst_valid got %b exp 0", key_valid); end
    rst_n = 1'b1;
    repeat (5) window('0);
    // Clean press of key (row 2, col 1) then release
    repeat (8) window(key(2, 1));
    vectors++;
    assert (key_code === 4'b1001) else begin miscompares++; $error("FAIL press_code got %b exp 1001", key_code); end
    repeat (6) window('0);
    // Single-sample bounce under column 3
    for (int i = 0; i < 8 && mc != 3; i++) window('0);
    window(key(0, 3));
    repeat (3) window('0);
    vectors++;
    assert (key_code === 4'b1001) else begin miscompares++; $error("FAIL bounce_code got %b exp 1001", key_code); end
    // Rows 1 and 3 together under column 0
    repeat (8) window(key(1, 0) | key(3, 0));
    vectors++;
    assert (key_code === 4'b0100) else begin miscompares++; $error("FAIL simul_code got %b exp 0100", key_code); end
    repeat (5) window('0);
    // Release glitch while held
    press_until_held(key(1, 2));
    window('0); window('0); window(key(1, 2)); window('0); window('0);
    vectors++;
    assert (key_held === 1'b1) else begin miscompares++; $error("FAIL glitch_held got %b exp 1", key_held); end
    window('0); window('0);
    // Asynchronous reset while held, between clock edges
    press_until_held(key(3, 3));
    #2 rst_n = 1'b0;
    #1;
    vectors += 4;
    assert (key_held === 1'b0) else begin miscompares++; $error("FAIL arst_held got %b exp 0", key_held); end
    assert (key_valid === 1'b0) else begin miscompares++; $error("FAIL arst_valid got %b exp 0", key_valid); end
    assert (col_out === 4'b1110) else begin miscompares++; $error("FAIL arst_col got %b exp 1110", col_out); end
    assert (key_code === 4'h0) else begin miscompares++; $error("FAIL arst_code got %h exp 0", key_code); end
    repeat (2) @(negedge clk);
    pressed = '0; rst_n = 1'b1;
    model_reset();
    // Random key activity
    for (int s = 0; s < 40; s++) begin
      sel = $urandom_range(0, 9);
      k = '0;
      if (sel >= 4) k[$urandom_range(0, 15)] = 1'b1;
      if (sel >= 8) k[$urandom_range(0, 15)] = 1'b1;
      len = $urandom_range(1, 7);
      repeat (len) window(k);
    end
    repeat (12) window('0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Column-scanning controller for the 4x4 matrix keypad. Drives one active-low column at a time and samples the four active-low rows through a synchronizer. It debounces press and release, then emits a 4-bit scan index `{row, col}` with a one-cycle valid strobe. The scan index feeds the keypad `Decoder` input directly, so the decoder's index-to-key mapping applies unchanged; for example, index 4'b0000 is key 1 and 4'b1101 is key 0.

## Interface
- `SCAN_DIV`, 1000: clock cycles each column is driven before the rows are sampled (dwell); must be ≥ 4.
- `DEBOUNCE_CNT`, 8: consecutive matching samples required to accept a press or a release; must be ≥ 1.

- `clk` in 1: single system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `row_in` in 4: keypad rows, active-low, externally pulled up; asynchronous to `clk`.
- `col_out` out 4: column drive, active-low one-hot; exactly one bit is 0 at all times.
- `key_code` out 4: `{row_idx[1:0], col_idx[1:0]}` of the last accepted key; holds its value until the next accept.
- `key_valid` out 1: one-cycle pulse when a debounced press is accepted.
- `key_held` out 1: high from the press accept until the release accept.

## Operation
- **Row synchronizer:** `row_in` passes through two flops (reset value 4'b1111). All decisions use the synchronized value `row_s`.
- **Dwell counter:** counts 0..SCAN_DIV-1 and wraps. A "sample" happens on the cycle where the count equals SCAN_DIV-1. The counter restarts at 0 on every state change and every column change.
- **Row priority:** when more than one bit of `row_s` is 0, the lowest index wins.
- **SCAN state:**
  - Drive `col_out = ~(4'b0001 << col_idx)`.
  - At a sample with `row_s != 4'b1111`: latch the winning `row_idx`, set the stable counter to 1, go to DEBOUNCE. The column stays driven.
  - At a sample with `row_s == 4'b1111`: advance `col_idx`, wrapping 3 → 0.
- **DEBOUNCE state:**
  - Each sample where the latched row bit is 0 increments the stable counter.
  - When the count reaches DEBOUNCE_CNT: load `key_code`, pulse `key_valid`, set `key_held`, go to HELD.
  - A sample where the latched row bit is 1 returns to SCAN on the same column with the stable counter cleared. Nothing is emitted.
  - With DEBOUNCE_CNT = 1, the accept happens on the detect sample itself; SCAN passes straight through.
- **HELD state:**
  - The column stays fixed. Other keys and other rows are ignored.
  - Each sample where the latched row bit is 1 increments the release counter.
  - A sample where the latched row bit is 0 clears the release counter.
  - When the release counter reaches DEBOUNCE_CNT: clear `key_held`, advance `col_idx`, go to SCAN.
  - No second `key_valid` is issued while in HELD (no auto-repeat).
- **Counter widths:** `$clog2(SCAN_DIV)` for the dwell counter and `$clog2(DEBOUNCE_CNT+1)` for the stable/release counters. Counters saturate and never wrap.

## Timing
- **Reset values:** `col_out` = 4'b1110, `col_idx` = 0, `key_code` = 4'h0, `key_valid` = 0, `key_held` = 0, state SCAN, all counters 0. Reset takes effect immediately, including mid-DEBOUNCE or mid-HELD.
- **Column period:** each column is driven for exactly SCAN_DIV cycles while idle. A full idle scan takes 4·SCAN_DIV cycles.
- **Press latency:** `key_valid`, `key_code` and `key_held` all update on the clock edge after the DEBOUNCE_CNT-th matching sample. The synchronizer adds 2 cycles between a `row_in` change and its visibility in `row_s`.
- **Release latency:** `key_held` falls on the edge after the DEBOUNCE_CNT-th consecutive release sample. The next column is driven starting the same cycle.
- **Pulse width:** `key_valid` is high for exactly 1 cycle per accepted press.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE_CNT = 3.
1. **Reset and idle scan:** hold `rst_n` low for 3 cycles with rows 4'b1111, then release. Outputs stay at reset values; `col_out` steps 1110 → 1101 → 1011 → 0111 → 1110, 4 cycles per step.
2. **Clean press:** hold row 2 low while column 1 is driven, for 3+ samples. Expect `key_code` = 4'b1001 (decoder key 8), exactly one `key_valid` pulse and `key_held` = 1. After release for 3 samples, `key_held` = 0 and `col_out` = 1011.
3. **Bounce rejection:** row 0 goes low for 1 sample under column 3, then returns high. Expect no `key_valid`, `key_code` unchanged, and scanning continuing from column 3.
4. **Simultaneous keys:** rows 1 and 3 held low under column 0. Expect `key_code` = 4'b0100 (key 4) and a single `key_valid`.
5. **Release glitch:** in HELD, drive 2 release samples, then 1 pressed sample, then 3 release samples. `key_held` must stay 1 until the final third release sample, and no extra `key_valid` may occur.
6. **Async reset mid-HELD:** assert `rst_n` low between clock edges. `key_held` and `key_valid` drop to 0 and `col_out` goes to 1110 without waiting for a clock edge.
